// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential CLA adder controller.
// Holds the FSM state enum, the slice width and the index-width helper.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Ports: a, b (4b), ci -> s (4b), co.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

endmodule

// File: rtl/cla_seq_ctrl.sv
// W-bit adder time-sharing one 4-bit CLA slice over NIBBLES cycles.
// Ports: clk, rst_n, in_valid/in_ready + a, b, cin request;
// out_valid/out_ready + sum, cout result; ovf when CLA_SEQ_OVF_EN.
module cla_seq_ctrl
  import cla_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int IW = idx_w(NIBBLES);

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [3:0]    s;
  logic          co;
  logic          last;

  // Operands shift right each RUN cycle, so the
  // active nibble always sits in the low slice.
  cla4_slice u_slice (
    .a  (a_q[SLICE_W-1:0]),
    .b  (b_q[SLICE_W-1:0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  assign last = (idx == IW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i))
              sum[i*SLICE_W +: SLICE_W] <= s;
          end
          carry <= co;
          a_q   <= a_q >> SLICE_W;
          b_q   <= b_q >> SLICE_W;
          idx   <= idx + 1'b1;
          if (last) begin
            idx  <= '0;
            cout <= co;
`ifdef CLA_SEQ_OVF_EN
            // Carry into the MSB is recovered
            // from the MSB sum and operand bits.
            ovf  <= s[3] ^ a_q[3] ^ b_q[3] ^ co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
